code_mem_ctrl: RTL and testbench



---
 rtl/code_mem_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_code_mem_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_mem_ctrl.sv
// Configurable-depth code memory: a byte store loaded over a valid/ready stream,
// checksum-verified by read-back, with a little-endian wrap-around word fetch port.
module code_mem_ctrl #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned WORD_BYTES  = 4,
  parameter int unsigned READ_REG    = 0
) (
  input  logic                    clk,
  input  logic                    reset_code_rom_n,
  input  logic                    prog_mode,
  input  logic                    prog_start,
  input  logic [ADDR_W-1:0]       prog_base_addr,
  input  logic [ADDR_W:0]         prog_len,
  input  logic [15:0]             prog_csum,
  input  logic                    prog_valid,
  input  logic [7:0]              prog_data,
  output logic                    prog_ready,
  output logic                    busy,
  output logic                    load_done,
  output logic                    load_error,
  output logic [1:0]              error_code,
  input  logic [ADDR_W-1:0]       fetch_addr,
  output logic [WORD_BYTES*8-1:0] fetch_data,
  output logic                    fetch_valid
);

  localparam int unsigned IdxW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam logic [ADDR_W+1:0] DepthExt = (ADDR_W+2)'(DEPTH_BYTES);

  localparam logic [1:0] ErrNone  = 2'd0;
  localparam logic [1:0] ErrRange = 2'd1;
  localparam logic [1:0] ErrAbort = 2'd2;
  localparam logic [1:0] ErrCsum  = 2'd3;

  typedef enum logic [1:0] {StIdle, StLoad, StCheck} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [15:0]         csum_q, csum_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [15:0]         wr_sum_q, wr_sum_d;
  logic [15:0]         rd_sum_q, rd_sum_d;
  logic                load_done_q, load_done_d;
  logic                load_error_q, load_error_d;
  logic [1:0]          error_code_q, error_code_d;

  logic [7:0]          mem_q [DEPTH_BYTES];
  logic                mem_we;
  logic [7:0]          rd_byte;
  logic [15:0]         rd_sum_next;
  logic [ADDR_W+1:0]   end_addr;
  logic                last_beat;

  logic [WORD_BYTES*8-1:0] fetch_word;
  logic [WORD_BYTES*8-1:0] fetch_word_gated;

  assign busy        = (state_q != StIdle);
  assign prog_ready  = (state_q == StLoad) && prog_mode;
  assign load_done   = load_done_q;
  assign load_error  = load_error_q;
  assign error_code  = error_code_q;

  // Load writes and check reads share the single pointer; a load never wraps the store.
  assign rd_byte     = mem_q[ptr_q[IdxW-1:0]];
  assign rd_sum_next = rd_sum_q + {8'h00, rd_byte};
  assign end_addr    = {2'b00, prog_base_addr} + {1'b0, prog_len};
  assign last_beat   = (count_q == len_q - (ADDR_W+1)'(1));

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    len_d        = len_q;
    csum_d       = csum_q;
    ptr_d        = ptr_q;
    count_d      = count_q;
    wr_sum_d     = wr_sum_q;
    rd_sum_d     = rd_sum_q;
    load_done_d  = load_done_q;
    load_error_d = load_error_q;
    error_code_d = error_code_q;
    mem_we       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (prog_start && prog_mode) begin
          base_d       = prog_base_addr;
          len_d        = prog_len;
          csum_d       = prog_csum;
          load_done_d  = 1'b0;
          load_error_d = 1'b0;
          error_code_d = ErrNone;
          if ((prog_len == '0) || (end_addr > DepthExt)) begin
            load_error_d = 1'b1;
            error_code_d = ErrRange;
          end else begin
            ptr_d    = prog_base_addr;
            count_d  = '0;
            wr_sum_d = '0;
            state_d  = StLoad;
          end
        end
      end

      StLoad: begin
        if (!prog_mode) begin
          load_error_d = 1'b1;
          error_code_d = ErrAbort;
          state_d      = StIdle;
        end else if (prog_valid) begin
          mem_we   = 1'b1;
          ptr_d    = ptr_q + ADDR_W'(1);
          count_d  = count_q + (ADDR_W+1)'(1);
          wr_sum_d = wr_sum_q + {8'h00, prog_data};
          if (last_beat) begin
            state_d  = StCheck;
            ptr_d    = base_q;
            count_d  = '0;
            rd_sum_d = '0;
          end
        end
      end

      StCheck: begin
        rd_sum_d = rd_sum_next;
        ptr_d    = ptr_q + ADDR_W'(1);
        count_d  = count_q + (ADDR_W+1)'(1);
        if (last_beat) begin
          state_d = StIdle;
          // Both the streamed sum and the read-back sum must match the expected value.
          if ((rd_sum_next == csum_q) && (wr_sum_q == csum_q)) begin
            load_done_d = 1'b1;
          end else begin
            load_error_d = 1'b1;
            error_code_d = ErrCsum;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_code_rom_n) begin
    if (!reset_code_rom_n) begin
      state_q      <= StIdle;
      base_q       <= '0;
      len_q        <= '0;
      csum_q       <= '0;
      ptr_q        <= '0;
      count_q      <= '0;
      wr_sum_q     <= '0;
      rd_sum_q     <= '0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
      error_code_q <= ErrNone;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      len_q        <= len_d;
      csum_q       <= csum_d;
      ptr_q        <= ptr_d;
      count_q      <= count_d;
      wr_sum_q     <= wr_sum_d;
      rd_sum_q     <= rd_sum_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
      error_code_q <= error_code_d;
    end
  end

  always_ff @(posedge clk or negedge reset_code_rom_n) begin
    if (!reset_code_rom_n) begin
      for (int unsigned i = 0; i < DEPTH_BYTES; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[ptr_q[IdxW-1:0]] <= prog_data;
    end
  end

  always_comb begin : p_fetch
    logic [IdxW-1:0] fidx;
    fidx       = '0;
    fetch_word = '0;
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      fidx = IdxW'((32'(fetch_addr) + i) % DEPTH_BYTES);
      fetch_word[8*i +: 8] = mem_q[fidx];
    end
  end

  assign fetch_word_gated = busy ? '0 : fetch_word;

  if (READ_REG != 0) begin : g_fetch_reg
    logic [WORD_BYTES*8-1:0] fetch_data_q, fetch_data_d;
    logic                    fetch_valid_q, fetch_valid_d;

    assign fetch_data_d  = fetch_word_gated;
    assign fetch_valid_d = !busy;

    always_ff @(posedge clk or negedge reset_code_rom_n) begin
      if (!reset_code_rom_n) begin
        fetch_data_q  <= '0;
        fetch_valid_q <= 1'b0;
      end else begin
        fetch_data_q  <= fetch_data_d;
        fetch_valid_q <= fetch_valid_d;
      end
    end

    assign fetch_data  = fetch_data_q;
    assign fetch_valid = fetch_valid_q;
  end else begin : g_fetch_comb
    assign fetch_data  = fetch_word_gated;
    assign fetch_valid = !busy;
  end

endmodule

// File: tb/tb_code_mem_ctrl.sv
// Randomized bench for code_mem_ctrl: one combinational and one registered fetch instance
// share stimulus and are scored against a byte-array model of the store and load status.
module tb_code_mem_ctrl;

  localparam int unsigned Depth = 64;
  localparam int unsigned AddrW = 7;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             prog_mode, prog_start, prog_valid;
  logic [AddrW-1:0] prog_base_addr, fetch_addr;
  logic [AddrW:0]   prog_len;
  logic [15:0]      prog_csum;
  logic [7:0]       prog_data;

  logic        ready0, busy0, done0, err0, fvalid0;
  logic        ready1, busy1, done1, err1, fvalid1;
  logic [1:0]  code0, code1;
  logic [31:0] fdata0, fdata1;

  int n_checks, n_errors, busy_cycles, last_fetch;
  logic [7:0] model_mem [Depth];
  logic [7:0] load_bytes [128];

  always #5 clk = ~clk;

  code_mem_ctrl #(.DEPTH_BYTES(Depth), .ADDR_W(AddrW), .WORD_BYTES(4), .READ_REG(0)) u_comb (
    .clk(clk), .reset_code_rom_n(reset_n), .prog_mode(prog_mode), .prog_start(prog_start),
    .prog_base_addr(prog_base_addr), .prog_len(prog_len), .prog_csum(prog_csum),
    .prog_valid(prog_valid), .prog_data(prog_data), .prog_ready(ready0), .busy(busy0),
    .load_done(done0), .load_error(err0), .error_code(code0), .fetch_addr(fetch_addr),
    .fetch_data(fdata0), .fetch_valid(fvalid0)
  );

  code_mem_ctrl #(.DEPTH_BYTES(Depth), .ADDR_W(AddrW), .WORD_BYTES(4), .READ_REG(1)) u_reg (
    .clk(clk), .reset_code_rom_n(reset_n), .prog_mode(prog_mode), .prog_start(prog_start),
    .prog_base_addr(prog_base_addr), .prog_len(prog_len), .prog_csum(prog_csum),
    .prog_valid(prog_valid), .prog_data(prog_data), .prog_ready(ready1), .busy(busy1),
    .load_done(done1), .load_error(err1), .error_code(code1), .fetch_addr(fetch_addr),
    .fetch_data(fdata1), .fetch_valid(fvalid1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (busy0) busy_cycles++;
  endtask

  function automatic logic [31:0] model_word(input int addr);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = model_mem[(addr + i) % Depth];
    return w;
  endfunction

  function automatic int sum_bytes(input int len);
    int s;
    s = 0;
    for (int i = 0; i < len; i++) s += load_bytes[i];
    return s;
  endfunction

  task automatic check_status(input string tag, input bit done, input bit err, input int code);
    chk({tag, "_done"}, done0, done);
    chk({tag, "_err"}, err0, err);
    chk({tag, "_code"}, code0, code);
    chk({tag, "_done_r"}, done1, done);
    chk({tag, "_err_r"}, err1, err);
    chk({tag, "_code_r"}, code1, code);
  endtask

  task automatic fetch_check(input int addr);
    fetch_addr = AddrW'(addr);
    #1;
    chk("fetch_comb", fdata0, model_word(addr));
    chk("fetch_valid_comb", fvalid0, 1);
    chk("fetch_reg_hold", fdata1, model_word(last_fetch));
    tick();
    chk("fetch_reg", fdata1, model_word(addr));
    chk("fetch_valid_reg", fvalid1, 1);
    last_fetch = addr;
  endtask

  task automatic do_load(input int base, input int len, input logic [15:0] csum,
                         input int stall_pct, input int abort_after, input int rst_in_check);
    int sent, guard;
    int sum;
    bit range_bad, aborted, ok;
    sum       = sum_bytes(len);
    range_bad = (len == 0) || (base + len > Depth);
    aborted   = 1'b0;
    prog_mode = 1'b1;
    prog_base_addr = AddrW'(base);
    prog_len  = (AddrW + 1)'(len);
    prog_csum = csum;
    prog_start = 1'b1;
    busy_cycles = 0;
    tick();
    prog_start = 1'b0;
    if (range_bad) begin
      chk("range_busy", busy0, 0);
      chk("range_busy_r", busy1, 0);
      check_status("range", 0, 1, 1);
      tick();
      chk("range_busy_later", busy0, 0);
      return;
    end
    chk("busy_gates_valid", fvalid0, 0);
    chk("busy_gates_data", fdata0, 0);
    chk("fvalid_reg_lag", fvalid1, 1);
    check_status("start_clears", 0, 0, 0);
    sent = 0;
    guard = 0;
    while (sent < len && guard < 3000) begin
      if (abort_after >= 0 && sent == abort_after) begin
        aborted = 1'b1;
        break;
      end
      prog_valid = ($urandom_range(99) >= stall_pct);
      prog_data  = load_bytes[sent];
      prog_start = ($urandom_range(7) == 0);
      prog_base_addr = AddrW'($urandom);
      #1;
      chk("prog_ready", ready0, 1);
      chk("prog_ready_r", ready1, 1);
      if (prog_valid) begin
        model_mem[base + sent] = prog_data;
        sent++;
      end
      tick();
      guard++;
      if (guard == 1) chk("fvalid_reg_drop", fvalid1, 0);
    end
    prog_valid = 1'b0;
    prog_start = 1'b0;
    if (aborted) begin
      prog_mode = 1'b0;
      #1;
      chk("abort_ready", ready0, 0);
      tick();
      chk("abort_idle", busy0, 0);
      chk("abort_idle_r", busy1, 0);
      chk("abort_ready_idle", ready0, 0);
      check_status("abort", 0, 1, 2);
      prog_mode = 1'b1;
      tick();
      return;
    end
    chk("load_accepted", sent, len);
    prog_mode = 1'($urandom_range(1));
    if (rst_in_check >= 0) begin
      repeat (rst_in_check) tick();
      chk("in_check", busy0, 1);
      #2 reset_n = 1'b0;
      #1;
      for (int i = 0; i < Depth; i++) model_mem[i] = 8'h00;
      chk("rst_busy", busy0, 0);
      chk("rst_busy_r", busy1, 0);
      chk("rst_ready", ready0, 0);
      chk("rst_fdata_r", fdata1, 0);
      check_status("rst", 0, 0, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      prog_mode = 1'b1;
      tick();
      return;
    end
    guard = 0;
    while (busy0 && guard < 4 * len + 8) begin
      tick();
      guard++;
    end
    chk("check_finished", busy0, 0);
    if (stall_pct == 0) chk("busy_cycles", busy_cycles, 2 * len);
    ok = (sum[15:0] == csum);
    check_status(ok ? "verify_ok" : "verify_bad", ok, !ok, ok ? 0 : 3);
    prog_mode = 1'b1;
    tick();
  endtask

  task automatic set_tp_bytes();
    load_bytes[0] = 8'h13; load_bytes[1] = 8'h00; load_bytes[2] = 8'h00; load_bytes[3] = 8'h00;
    load_bytes[4] = 8'h93; load_bytes[5] = 8'h00; load_bytes[6] = 8'h10; load_bytes[7] = 8'h00;
  endtask

  initial begin
    int base, len, sum;
    logic [15:0] csum;
    n_checks = 0;
    n_errors = 0;
    last_fetch = 0;
    busy_cycles = 0;
    reset_n = 1'b0;
    prog_mode = 1'b0; prog_start = 1'b0; prog_valid = 1'b0; prog_data = '0;
    prog_base_addr = '0; prog_len = '0; prog_csum = '0; fetch_addr = '0;
    for (int i = 0; i < Depth; i++) model_mem[i] = 8'h00;
    #3;
    chk("reset_busy", busy0, 0);
    chk("reset_ready", ready0, 0);
    chk("reset_fdata", fdata0, 0);
    chk("reset_fdata_r", fdata1, 0);
    chk("reset_fvalid_r", fvalid1, 0);
    check_status("reset", 0, 0, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();

    set_tp_bytes();
    do_load(0, 8, 16'h00B6, 0, -1, -1);
    fetch_check(0);
    chk("tp_word0", fdata0, 32'h0000_0013);
    fetch_check(4);
    chk("tp_word4", fdata0, 32'h0010_0093);

    load_bytes[0] = 8'h11;
    do_load(0, 1, 16'h0011, 0, -1, -1);
    load_bytes[0] = 8'hAA; load_bytes[1] = 8'hBB; load_bytes[2] = 8'hCC; load_bytes[3] = 8'hDD;
    do_load(60, 4, 16'h030E, 0, -1, -1);
    fetch_check(62);
    fetch_check(66);
    fetch_check(127);

    do_load(60, 8, 16'h0000, 0, -1, -1);
    fetch_check(60);
    do_load(5, 0, 16'h0000, 0, -1, -1);

    prog_mode = 1'b0;
    prog_start = 1'b1;
    prog_base_addr = '0;
    prog_len = 8'd8;
    tick();
    prog_start = 1'b0;
    chk("nomode_busy", busy0, 0);
    check_status("nomode_keeps", 0, 1, 1);
    prog_mode = 1'b1;

    for (int i = 0; i < 8; i++) load_bytes[i] = 8'(8'h21 + i);
    do_load(8, 8, 16'h0000, 0, 3, -1);
    fetch_check(8);
    fetch_check(10);

    set_tp_bytes();
    do_load(16, 8, 16'h0000, 0, -1, -1);
    do_load(16, 8, 16'h00B6, 40, -1, -1);
    fetch_check(16);
    fetch_check(20);

    repeat (8) begin
      base = $urandom_range(Depth - 1);
      len  = $urandom_range(24);
      for (int i = 0; i < len; i++) load_bytes[i] = 8'($urandom);
      sum  = sum_bytes(len);
      csum = ($urandom_range(3) == 0) ? 16'(sum + 1) : 16'(sum);
      do_load(base, len, csum, $urandom_range(50), -1, -1);
      repeat (3) fetch_check($urandom_range(127));
    end

    set_tp_bytes();
    do_load(0, 8, 16'h00B6, 0, -1, 3);
    fetch_check(0);
    fetch_check(60);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
